// File: rtl/si_bullet_pkg.sv
// Shared defaults and index helper for the player-bullet datapath.
package si_bullet_pkg;

    localparam int ROWS_DEF     = 8;
    localparam int COLS_DEF     = 16;
    localparam int TICK_MAX_DEF = 2500000;
    localparam int TICK_W_DEF   = 22;

    localparam int ROW_W = $clog2(ROWS_DEF);
    localparam int COL_W = $clog2(COLS_DEF);
    localparam int IDX_W = $clog2(ROWS_DEF * COLS_DEF);

    // Bitmap index of a playfield cell: row-major, row*cols+col.
    function automatic int cell_idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/si_tick_prescaler.sv
// Move-tick prescaler: free-runs while enabled, emits a one-cycle low pulse
// every TICK_MAX cycles, and is held at zero while disabled.
module si_tick_prescaler #(
    parameter int TICK_MAX = 2500000,
    parameter int TICK_W   = 22
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_n,
    output logic tick_n
);

    logic [TICK_W-1:0] cnt_q;

    // Count, wrap at TICK_MAX-1 and register the wrap as the tick pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_n <= 1'b1;
        end else if (en_n) begin
            cnt_q  <= '0;
            tick_n <= 1'b1;
        end else if (cnt_q == TICK_W'(TICK_MAX - 1)) begin
            cnt_q  <= '0;
            tick_n <= 1'b0;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
            tick_n <= 1'b1;
        end
    end

endmodule

// File: rtl/si_bullet_datapath.sv
// Player-bullet datapath: position register, move-tick prescaler and hit
// detection against the invader bitmap. Status lines feed the shoot FSM.
module si_bullet_datapath
    import si_bullet_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int TICK_MAX = TICK_MAX_DEF,
    parameter int TICK_W   = TICK_W_DEF,
    localparam int RW      = $clog2(ROWS),
    localparam int CW      = $clog2(COLS),
    localparam int IW      = $clog2(ROWS * COLS)
) (
    input  logic              SI_BULLET_CLOCK_50,
    input  logic              SI_BULLET_RESET_InLow,
    input  logic              SI_BULLET_ENABLEC_InLow,
    input  logic              SI_BULLET_LOAD_InLow,
    input  logic              SI_BULLET_CLEAR_InLow,
    input  logic              SI_BULLET_CTLMUX_IN,
    input  logic [CW-1:0]     SI_BULLET_PLAYERCOL_IN,
    input  logic [ROWS*COLS-1:0] SI_BULLET_INVADERS_IN,
    output logic              SI_BULLET_COUNT1_OUTLow,
    output logic              SI_BULLET_COUNT7_OUTLow,
    output logic              SI_BULLET_BULLET_OUTLow,
    output logic              SI_BULLET_HIT_OUT,
    output logic [IW-1:0]     SI_BULLET_HITIDX_OUT,
    output logic [RW-1:0]     SI_BULLET_ROW_OUT,
    output logic [CW-1:0]     SI_BULLET_COL_OUT,
    output logic              SI_BULLET_ACTIVE_OUT
);

    logic          clk;
    logic          rst_n;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] launch_col;
    logic [IW-1:0] idx;
    logic          active;
    logic          overlap;
    logic          bullet_n_q;
    logic          hit_q;
    logic [IW-1:0] hitidx_q;

    assign clk   = SI_BULLET_CLOCK_50;
    assign rst_n = SI_BULLET_RESET_InLow;

    si_tick_prescaler #(
        .TICK_MAX (TICK_MAX),
        .TICK_W   (TICK_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_n   (SI_BULLET_ENABLEC_InLow),
        .tick_n (SI_BULLET_COUNT1_OUTLow)
    );

    // Player column clamped so a non-power-of-two COLS never yields an off-field index.
    always_comb begin
        launch_col = SI_BULLET_PLAYERCOL_IN;
        if (int'(SI_BULLET_PLAYERCOL_IN) > COLS - 1)
            launch_col = CW'(COLS - 1);
    end

    // Position register: clear beats load; stepping up saturates at the top row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (!SI_BULLET_CLEAR_InLow) begin
            row_q <= '0;
            col_q <= '0;
        end else if (!SI_BULLET_LOAD_InLow) begin
            if (!SI_BULLET_CTLMUX_IN) begin
                row_q <= RW'(ROWS - 1);
                col_q <= launch_col;
            end else if (row_q != '0) begin
                row_q <= row_q - 1'b1;
            end
        end
    end

    assign active  = (row_q != '0);
    assign idx     = IW'(cell_idx(int'(row_q), int'(col_q), COLS));
    assign overlap = active && SI_BULLET_INVADERS_IN[idx];

    // Registered overlap; hit pulses only on the first cycle of a new overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bullet_n_q <= 1'b1;
            hit_q      <= 1'b0;
            hitidx_q   <= '0;
        end else begin
            bullet_n_q <= ~overlap;
            hit_q      <= overlap && bullet_n_q;
            if (overlap && bullet_n_q)
                hitidx_q <= idx;
        end
    end

    assign SI_BULLET_COUNT7_OUTLow = active;
    assign SI_BULLET_ACTIVE_OUT    = active;
    assign SI_BULLET_BULLET_OUTLow = bullet_n_q;
    assign SI_BULLET_HIT_OUT       = hit_q;
    assign SI_BULLET_HITIDX_OUT    = hitidx_q;
    assign SI_BULLET_ROW_OUT       = row_q;
    assign SI_BULLET_COL_OUT       = col_q;

endmodule
